// File: rtl/design08_sched.sv
// Two-client round-robin scheduler in front of one mkDesign_08 instance: issues
// start, collects result/check, and returns a tagged response (or a timeout).
module design08_sched #(
  parameter int WIDTH   = 12,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             EN_req0,
  output logic             RDY_req0,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             EN_req1,
  output logic             RDY_req1,
  output logic [WIDTH-1:0] dsn_start_a,
  output logic [WIDTH-1:0] dsn_start_b,
  output logic             dsn_EN_start,
  input  logic             dsn_RDY_start,
  input  logic [WIDTH-1:0] dsn_resresult,
  input  logic             dsn_RDY_result,
  output logic             dsn_EN_check,
  input  logic [WIDTH-1:0] dsn_chresult,
  input  logic             dsn_RDY_check,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_check,
  output logic             rsp_timeout,
  input  logic             EN_rsp,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  // Handshakes: a method fires in a cycle where its RDY_* and EN_* are both high;
  // RDY_* never depends on the matching EN_*, and a fired method is consumed at the
  // next rising edge.

  typedef enum logic [2:0] {
    st_idle  = 3'd0,
    st_issue = 3'd1,
    st_wait  = 3'd2,
    st_check = 3'd3,
    st_resp  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t           state, state_n;
  logic             last_grant;
  logic [CNT_W-1:0] timer;
  logic [WIDTH-1:0] op_a, op_b, res_q, chk_q;
  logic             tag, to_q;
  logic             accept, grant, timer_hit;

  always_comb begin
    state_n   = state;
    accept    = (state == st_idle) && (EN_req0 || EN_req1);
    // On a tie the client that did not win last time gets the grant.
    grant     = (EN_req0 && EN_req1) ? ~last_grant : EN_req1;
    timer_hit = (timer == TO);
    case (state)
      st_idle:  if (accept) state_n = st_issue;
      st_issue: if (dsn_RDY_start) state_n = st_wait;
      st_wait:  if (dsn_RDY_result) state_n = st_check;
                else if (timer_hit) state_n = st_resp;
      st_check: if (dsn_RDY_check || timer_hit) state_n = st_resp;
      st_resp:  if (EN_rsp) state_n = st_idle;
      default:  state_n = st_idle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= st_idle;
      last_grant <= 1'b1;
      timer      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      tag        <= 1'b0;
      res_q      <= '0;
      chk_q      <= '0;
      to_q       <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        st_idle: if (accept) begin
          op_a  <= grant ? req1_a : req0_a;
          op_b  <= grant ? req1_b : req0_b;
          tag   <= grant;
          timer <= '0;
          to_q  <= 1'b0;
        end
        st_wait: begin
          if (dsn_RDY_result) res_q <= dsn_resresult;
          else if (timer_hit) begin
            to_q  <= 1'b1;
            res_q <= '0;
            chk_q <= '0;
          end else timer <= timer + CNT_W'(1);
        end
        st_check: begin
          // The timer keeps counting from where WAIT left it.
          if (dsn_RDY_check) chk_q <= dsn_chresult;
          else if (timer_hit) begin
            to_q  <= 1'b1;
            res_q <= '0;
            chk_q <= '0;
          end else timer <= timer + CNT_W'(1);
        end
        st_resp: if (EN_rsp) last_grant <= tag;
        default: ;
      endcase
    end
  end

  // Every output is held at zero while reset is asserted, even mid-transaction.
  assign RDY_req0     = !RST && (state == st_idle);
  assign RDY_req1     = !RST && (state == st_idle);
  assign dsn_start_a  = RST ? '0 : op_a;
  assign dsn_start_b  = RST ? '0 : op_b;
  assign dsn_EN_start = !RST && (state == st_issue) && dsn_RDY_start;
  assign dsn_EN_check = !RST && (state == st_check) && dsn_RDY_check;
  assign rsp_valid    = !RST && (state == st_resp);
  assign rsp_id       = !RST && tag;
  assign rsp_result   = RST ? '0 : res_q;
  assign rsp_check    = RST ? '0 : chk_q;
  assign rsp_timeout  = !RST && to_q;
  assign busy         = !RST && (state != st_idle);
  assign state_dbg    = RST ? 3'd0 : state;

endmodule
